uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Receive end of the UART link. Oversamples the serial RX_IN line at PRESCALE clocks per bit.
//  Recovers start/data/parity/stop fields and presents a parallel byte with a one-cycle DATA_VALID.
//  Flags parity and stop-bit errors. Frame format matches uart_tx: start(0), data LSB-first,
//  optional parity, stop(1).
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  PRESCALE_W  6  width of PRESCALE input; legal PRESCALE values are 8, 16 and 32
// PORTS
//  CLK        in   1           oversampling clock; one clock, all logic on posedge
//  RST        in   1           asynchronous, active-low reset
//  RX_IN      in   1           serial line, idle high, already synchronised upstream
//  PAR_EN     in   1           1 = parity bit present in frame
//  PAR_TYP    in   1           1 = parity bit is ^data (even); 0 = ~^data (odd)
//  PRESCALE   in   PRESCALE_W  CLK cycles per bit
//  P_DATA     out  DATA_WIDTH  received byte
//  DATA_VALID out  1           one-cycle pulse: P_DATA holds a good frame
//  PAR_ERR    out  1           one-cycle pulse: parity mismatch
//  STP_ERR    out  1           one-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  - Reset (RST=0, async): FSM=IDLE, counters=0, P_DATA=0, DATA_VALID=PAR_ERR=STP_ERR=0.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - Counters: edge_cnt runs 0..PRESCALE-1 within each bit; bit_cnt counts data bits 0..DATA_WIDTH-1.
//  - IDLE:
//    - RX_IN==0 on a clock edge moves to START with edge_cnt=0.
//    - PAR_EN, PAR_TYP and PRESCALE are latched at that same edge.
//    - Changes to these inputs mid-frame are ignored.
//  - Sample point: edge_cnt==PRESCALE/2 (e.g. 4 for PRESCALE=8).
//  - START: if the sampled bit is 1, the event is a glitch: return to IDLE at the end of the bit,
//    with no outputs. Otherwise go to DATA.
//  - DATA: sampled bits shift into the shift register LSB-first. After bit DATA_WIDTH-1, go to
//    PARITY if PAR_EN, else STOP.
//  - PARITY: the sampled bit is compared with the parity computed from the shift register per PAR_TYP.
//  - STOP: the sample is taken at the mid point. On the following edge (edge_cnt==PRESCALE/2+1),
//    outputs are updated and the FSM returns to IDLE. Returning early allows a back-to-back start
//    bit to be detected without loss.
//  - Output update, single cycle:
//    - No errors: P_DATA <= shift reg and DATA_VALID=1.
//    - Any error: P_DATA unchanged, DATA_VALID=0, and PAR_ERR and/or STP_ERR =1. Both may assert together.
//    - P_DATA holds until the next good frame.
//  - Latency: DATA_VALID asserts PRESCALE/2+2 cycles after the stop-bit start edge.
//  - Back-to-back frames: RX_IN low in the IDLE cycle right after the update starts a new frame
//    with no idle bit required.
//  - Reset mid-frame: returns to IDLE immediately. The partial byte is discarded; no pulses.
//  - Illegal PRESCALE (not 8/16/32): treated as 8.
// CONFIGURATION
//  - RX_MAJORITY_VOTE_EN defined:
//    - The bit value is the majority of the samples at PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
//    - The decision is available at edge PRESCALE/2+1.
//    - All later timing shifts by +1 cycle, including the STOP->IDLE return and DATA_VALID.
//  - RX_MAJORITY_VOTE_EN undefined: single sample at PRESCALE/2. The vote logic is not built.
// STRUCTURE
//  - Shared package uart_pkg:
//    - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
//    - DATA_WIDTH default.
//    - Legal PRESCALE constants: 8, 16, 32.
//    - Parity function par_bit(data, typ), shared with uart_tx so both ends agree.
//  - One sub-module, uart_rx_sampler:
//    - Owns edge_cnt, sample-point decode and the optional majority vote.
//    - Outputs: sampled_bit, sample_strobe, bit_end.
//  - FSM, shift register and checks stay in the top module.
// TESTING
//  1. PRESCALE=8, PAR_EN=1, PAR_TYP=1, frame 0x5D with parity 1 and stop 1
//     -> P_DATA=0x5D, DATA_VALID for 1 cycle, no errors.
//  2. Same frame with parity bit 0 -> PAR_ERR=1 for 1 cycle, DATA_VALID=0, P_DATA keeps its previous value.
//  3. PRESCALE=16, PAR_EN=0, frame 0xA3 with stop bit 0 -> STP_ERR=1, DATA_VALID=0.
//  4. RX_IN low for 2 cycles, then high (PRESCALE=8) -> no outputs, FSM back in IDLE.
//  5. Two back-to-back frames, 0x5D then 0x62, PAR_EN=1, PAR_TYP=0, no idle gap
//     -> two DATA_VALID pulses, 10*PRESCALE+? spacing matching the frame length, bytes in order.
//  6. RST low during bit 4 of a frame -> all outputs 0 at once; the next clean frame 0x3C is received correctly.
//  - Run the whole set with and without RX_MAJORITY_VOTE_EN.
//  - With the macro defined, a 1-cycle glitch at the data sample point must not change the received byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame defaults, legal PRESCALE values
// and the parity/majority helpers used by both ends of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_8     = 8;
    localparam int PRESCALE_16    = 16;
    localparam int PRESCALE_32    = 32;

    // typ=1 gives ^data, typ=0 gives ~^data; uart_tx uses the same function
    function automatic logic par_bit(input logic [DATA_WIDTH_DEF-1:0] data, input logic typ);
        return typ ? (^data) : (~^data);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Parallel-side and serial-line signal bundle of the oversampled UART receiver.
interface uart_rx_oversampled_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and sample-point decode for the UART receiver.
// With RX_MAJORITY_VOTE_EN defined the bit is a 3-sample vote decided one edge later.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  run,
    input  logic                  rx,
    output logic                  sampled_bit,
    output logic                  sample_strobe,
    output logic                  bit_end
);
    logic [PRESCALE_W-1:0] edge_cnt_r;
    logic [PRESCALE_W-1:0] half_s;

    assign half_s  = {1'b0, prescale[PRESCALE_W-1:1]};
    assign bit_end = run && (edge_cnt_r == (prescale - PRESCALE_W'(1)));

    // Edge counter: held at zero while idle so the start edge begins at count 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= '0;
        end else if (!run || bit_end) begin
            edge_cnt_r <= '0;
        end else begin
            edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic smp_early_r;
    logic smp_mid_r;

    // Capture the two samples that precede the decision edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_early_r <= 1'b1;
            smp_mid_r   <= 1'b1;
        end else begin
            if (edge_cnt_r == (half_s - PRESCALE_W'(1))) begin
                smp_early_r <= rx;
            end
            if (edge_cnt_r == half_s) begin
                smp_mid_r <= rx;
            end
        end
    end

    // Vote decision at the third sample point
    always_comb begin
        sample_strobe = run && (edge_cnt_r == (half_s + PRESCALE_W'(1)));
        sampled_bit   = maj3(smp_early_r, smp_mid_r, rx);
    end
`else
    // Single mid-bit sample
    always_comb begin
        sample_strobe = run && (edge_cnt_r == half_s);
        sampled_bit   = rx;
    end
`endif

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: start/data/[parity]/stop FSM, shift register and error checks.
// Optional build macro RX_MAJORITY_VOTE_EN selects 3-sample majority voting per bit.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_rx_oversampled_if.slave   bus
);
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

    uart_state_e           state_r, state_nx_s;
    logic [PRESCALE_W-1:0] prescale_r, prescale_legal_s;
    logic                  par_en_r, par_typ_r;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r, p_data_r;
    logic                  data_valid_r, par_err_r, stp_err_r;
    logic                  par_bad_r, last_smp_r, smp_seen_r;
    logic                  sampled_bit_s, sample_strobe_s, bit_end_s;
    logic                  load_cfg_s, run_s, shift_en_s, par_chk_s, update_s, last_bit_s;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk           (CLK),
        .rst_n         (RST),
        .prescale      (prescale_r),
        .run           (run_s),
        .rx            (bus.RX_IN),
        .sampled_bit   (sampled_bit_s),
        .sample_strobe (sample_strobe_s),
        .bit_end       (bit_end_s)
    );

    // Anything other than 16 or 32 falls back to 8
    always_comb begin
        case (bus.PRESCALE)
            PRESCALE_W'(PRESCALE_16): prescale_legal_s = PRESCALE_W'(PRESCALE_16);
            PRESCALE_W'(PRESCALE_32): prescale_legal_s = PRESCALE_W'(PRESCALE_32);
            default:                  prescale_legal_s = PRESCALE_W'(PRESCALE_8);
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    assign last_bit_s = (bit_cnt_r == BIT_CNT_W'(DATA_WIDTH - 1));

    // FSM next-state logic; STOP leaves one edge after its sample so a back-to-back start is caught
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:   if (!bus.RX_IN) state_nx_s = ST_START; else state_nx_s = ST_IDLE;
            ST_START:  if (bit_end_s) state_nx_s = last_smp_r ? ST_IDLE : ST_DATA;
                       else state_nx_s = ST_START;
            ST_DATA:   if (bit_end_s && last_bit_s) state_nx_s = par_en_r ? ST_PARITY : ST_STOP;
                       else state_nx_s = ST_DATA;
            ST_PARITY: if (bit_end_s) state_nx_s = ST_STOP; else state_nx_s = ST_PARITY;
            ST_STOP:   if (smp_seen_r) state_nx_s = ST_IDLE; else state_nx_s = ST_STOP;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output decode driving the datapath
    always_comb begin
        load_cfg_s = (state_r == ST_IDLE) && !bus.RX_IN;
        run_s      = (state_r != ST_IDLE);
        shift_en_s = (state_r == ST_DATA) && sample_strobe_s;
        par_chk_s  = (state_r == ST_PARITY) && sample_strobe_s;
        update_s   = (state_r == ST_STOP) && smp_seen_r;
    end

    // Frame configuration, frozen for the whole frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_r <= PRESCALE_W'(PRESCALE_8);
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
        end else if (load_cfg_s) begin
            prescale_r <= prescale_legal_s;
            par_en_r   <= bus.PAR_EN;
            par_typ_r  <= bus.PAR_TYP;
        end
    end

    // Shift register, bit counter and per-bit sample bookkeeping
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            par_bad_r  <= 1'b0;
            last_smp_r <= 1'b1;
            smp_seen_r <= 1'b0;
        end else begin
            if (shift_en_s) shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
            if (state_r == ST_IDLE) begin
                bit_cnt_r <= '0;
            end else if ((state_r == ST_DATA) && bit_end_s) begin
                bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + BIT_CNT_W'(1);
            end
            if (load_cfg_s) begin
                par_bad_r <= 1'b0;
            end else if (par_chk_s) begin
                par_bad_r <= (sampled_bit_s != par_bit(shift_r, par_typ_r));
            end
            if (sample_strobe_s) last_smp_r <= sampled_bit_s;
            if ((state_r == ST_IDLE) || bit_end_s) begin
                smp_seen_r <= 1'b0;
            end else if (sample_strobe_s) begin
                smp_seen_r <= 1'b1;
            end
        end
    end

    // Registered result: one-cycle pulses, P_DATA only moves on a clean frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_r     <= '0;
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            data_valid_r <= update_s && !par_bad_r && last_smp_r;
            par_err_r    <= update_s && par_bad_r;
            stp_err_r    <= update_s && !last_smp_r;
            if (update_s && !par_bad_r && last_smp_r) p_data_r <= shift_r;
        end
    end

    assign bus.P_DATA     = p_data_r;
    assign bus.DATA_VALID = data_valid_r;
    assign bus.PAR_ERR    = par_err_r;
    assign bus.STP_ERR    = stp_err_r;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames push expected results,
// a negedge monitor pops and checks each output pulse (flags, byte, cycle).
module tb_uart_rx_oversampled;
    import uart_pkg::*;

`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    typedef struct {
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] d;
        int         cyc;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    int   vq[$];
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_oversampled_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx_oversampled #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d valid=%b par=%b stp=%b data=%h expected=none",
                         cyc, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_flags"}, {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR},
                    {29'd0, e.v, e.pe, e.se});
                chk({e.name, "_data"}, {24'd0, bus.P_DATA}, {24'd0, e.d});
                chk({e.name, "_cycle"}, cyc, e.cyc);
                if (bus.DATA_VALID) vq.push_back(cyc);
            end
        end
    end

    task automatic drive_bit(input logic v, input int p);
        bus.RX_IN = v;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int p, input logic pen, input logic typ);
        bus.PRESCALE = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = typ;
    endtask

    // Sends one frame with bit period p, called right after a posedge (+1)
    task automatic send_frame(input string name, input int p, input logic [7:0] d, input logic pen,
                              input logic pv, input logic sv, input int glitch_k,
                              input logic ev, input logic epe, input logic ese, input logic poke);
        exp_t e;
        logic [5:0] sv_pre;
        logic sv_pen, sv_typ;
        int nb;
        nb     = pen ? 10 : 9;
        e.v    = ev;
        e.pe   = epe;
        e.se   = ese;
        e.name = name;
        e.cyc  = cyc + 1 + nb * p + p / 2 + 2 + VOTE;
        if (ev) last_good = d;
        e.d = last_good;
        if (ev || epe || ese) q.push_back(e);
        drive_bit(1'b0, p);
        sv_pre = bus.PRESCALE;
        sv_pen = bus.PAR_EN;
        sv_typ = bus.PAR_TYP;
        if (poke) cfg(8, ~sv_pen, ~sv_typ);
        for (int k = 0; k < 8; k++) begin
            if (k == glitch_k) begin
                bus.RX_IN = d[k];
                repeat (p / 2 + 1) @(posedge clk);
                #1;
                bus.RX_IN = ~d[k];
                @(posedge clk);
                #1;
                bus.RX_IN = d[k];
                repeat (p - p / 2 - 2) @(posedge clk);
                #1;
            end else begin
                drive_bit(d[k], p);
            end
        end
        if (pen) drive_bit(pv, p);
        drive_bit(sv, p);
        if (poke) begin
            bus.PRESCALE = sv_pre;
            bus.PAR_EN   = sv_pen;
            bus.PAR_TYP  = sv_typ;
        end
    endtask

    initial begin
        bus.RX_IN = 1'b1;
        cfg(8, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_p_data", {24'd0, bus.P_DATA}, 0);
        chk("reset_valid", {31'd0, bus.DATA_VALID}, 0);
        chk("reset_par_err", {31'd0, bus.PAR_ERR}, 0);
        chk("reset_stp_err", {31'd0, bus.STP_ERR}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_bit(1'b1, 10);

        // 1: 0x5D even parity, parity bit 1
        cfg(8, 1'b1, 1'b1);
        send_frame("t1_good", 8, 8'h5D, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        // 2: wrong parity bit
        send_frame("t2_par", 8, 8'h5D, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        // both errors together
        send_frame("t2b_both", 8, 8'h5D, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        // 3: PRESCALE=16, no parity, stop bit 0
        cfg(16, 1'b0, 1'b0);
        send_frame("t3_stp", 16, 8'hA3, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 64);
        // 4: two-cycle start glitch
        cfg(8, 1'b0, 1'b0);
        bus.RX_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive_bit(1'b1, 24);
        // 5: back-to-back odd-parity frames
        cfg(8, 1'b1, 1'b0);
        vq.delete();
        send_frame("t5_a", 8, 8'h5D, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame("t5_b", 8, 8'h62, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        chk("t5_count", vq.size(), 2);
        if (vq.size() == 2) chk("t5_spacing", vq[1] - vq[0], 88);
        // 6: reset during data bit 4
        cfg(8, 1'b0, 1'b0);
        drive_bit(1'b0, 8);
        for (int k = 0; k < 4; k++) drive_bit(k[0], 8);
        bus.RX_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("t6_rst_p_data", {24'd0, bus.P_DATA}, 0);
        chk("t6_rst_valid", {31'd0, bus.DATA_VALID}, 0);
        chk("t6_rst_par_err", {31'd0, bus.PAR_ERR}, 0);
        chk("t6_rst_stp_err", {31'd0, bus.STP_ERR}, 0);
        last_good = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_bit(1'b1, 8);
        send_frame("t6_good", 8, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        // illegal PRESCALE 12 behaves as 8
        cfg(12, 1'b0, 1'b0);
        send_frame("t7_illegal", 8, 8'hC5, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        // PRESCALE=32 with config inputs changed mid-frame
        cfg(32, 1'b1, 1'b1);
        send_frame("t8_cfg_hold", 32, 8'hA3, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 64);
`ifdef RX_MAJORITY_VOTE_EN
        // single-cycle glitch on the mid sample of data bit 3
        cfg(8, 1'b0, 1'b0);
        send_frame("t9_vote", 8, 8'h5D, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
`endif
        drive_bit(1'b1, 50);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
